// File: rtl/frame_sequencer_pkg.sv
// Shared constants, state encoding and layer-step helper for the frame sequencer.
package frame_sequencer_pkg;

  localparam int MAT_ROWS = 16;
  localparam int MAT_COLS = 16;
  localparam int MAT_BITS = MAT_ROWS * MAT_COLS;
  localparam int IDX_W    = 4;

  typedef enum logic [1:0] {
    ST_IDLE  = 2'd0,
    ST_SHOW  = 2'd1,
    ST_BLANK = 2'd2
  } state_e;

  // Advance to the next layer, wrapping back to layer 0 after the last one.
  function automatic logic [IDX_W-1:0] next_layer(input logic [IDX_W-1:0] idx,
                                                  input int nframe);
    if (idx == IDX_W'(nframe - 1)) return '0;
    return idx + IDX_W'(1);
  endfunction

endpackage

// File: rtl/frame_sequencer_store.sv
// Double-buffered layer memory: rows are written into the back bank while the
// front bank supplies a full 256-bit layer for display.
module frame_store
  import frame_sequencer_pkg::*;
#(
  parameter int NFRAME = 16
) (
  input  logic                clk_i,
  input  logic                rst_i,
  input  logic                swap_i,
  input  logic                wr_en_i,
  input  logic [IDX_W-1:0]    wr_frame_i,
  input  logic [3:0]          wr_row_i,
  input  logic [0:MAT_COLS-1] wr_data_i,
  input  logic [IDX_W-1:0]    rd_idx_i,
  output logic [0:MAT_BITS-1] rd_mat_o
);

  localparam int FR_W = (NFRAME > 1) ? $clog2(NFRAME) : 1;

  logic                front_q;
  logic [0:MAT_COLS-1] mem_q [0:1][0:NFRAME-1][0:MAT_ROWS-1];
  logic [FR_W-1:0]     wr_fr;
  logic [FR_W-1:0]     rd_fr;
  logic                unused_hi_bits;

  // Layer numbers above NFRAME-1 alias onto the low bits.
  assign wr_fr          = wr_frame_i[FR_W-1:0];
  assign rd_fr          = rd_idx_i[FR_W-1:0];
  assign unused_hi_bits = ^{wr_frame_i, rd_idx_i};

  // Front-bank select flips once per executed swap.
  always_ff @(posedge clk_i or posedge rst_i) begin
    if (rst_i) front_q <= 1'b0;
    else if (swap_i) front_q <= ~front_q;
  end

  // Row writes only ever land in the bank that is not being displayed.
  always_ff @(posedge clk_i) begin
    if (wr_en_i) mem_q[~front_q][wr_fr][wr_row_i] <= wr_data_i;
  end

  // Assemble the selected front layer in row-major order.
  always_comb begin
    rd_mat_o = '0;
    for (int r = 0; r < MAT_ROWS; r++) begin
      rd_mat_o[r*MAT_COLS +: MAT_COLS] = mem_q[front_q][rd_fr][4'(r)];
    end
  end

endmodule

// File: rtl/frame_sequencer.sv
// Volumetric layer sequencer: dwell/blank timing FSM, tear-free bank swap
// handshake and registered matrix output towards the 16x16 driver.
module frame_sequencer
  import frame_sequencer_pkg::*;
#(
  parameter int NFRAME = 16,
  parameter int DWELL  = 1024,
  parameter int BLANK  = 8
) (
  input  logic                clock,
  input  logic                reset,
  input  logic                enable,
  input  logic                sync,
  input  logic                wr_en,
  output logic                wr_ready,
  input  logic [3:0]          wr_frame,
  input  logic [3:0]          wr_row,
  input  logic [0:15]         wr_data,
  input  logic                swap_req,
  output logic                swap_ack,
  output logic [0:255]        mat,
  output logic [3:0]          frame_idx,
  output logic                frame_start
);

  localparam int CNT_MAX = (DWELL > BLANK) ? DWELL : BLANK;
  localparam int CNT_W   = $clog2(CNT_MAX + 1);
  localparam logic [CNT_W-1:0] DWELL_LAST = CNT_W'(DWELL - 1);
  localparam logic [CNT_W-1:0] BLANK_LAST = CNT_W'((BLANK > 0) ? BLANK - 1 : 0);

  state_e              state_q, state_d;
  logic [IDX_W-1:0]    idx_q, idx_d;
  logic [CNT_W-1:0]    cnt_q, cnt_d;
  logic                pending_q, pending_d;
  logic                swap_ack_q, swap_ack_d;
  logic [0:MAT_BITS-1] mat_q, mat_d;
  logic [IDX_W-1:0]    frame_idx_q, frame_idx_d;
  logic                frame_start_q, frame_start_d;
  logic [0:MAT_BITS-1] front_mat;
  logic                load0;
  logic                restart;
  logic                do_swap;

  frame_store #(.NFRAME(NFRAME)) u_store (
    .clk_i      (clock),
    .rst_i      (reset),
    .swap_i     (do_swap),
    .wr_en_i    (wr_en & wr_ready),
    .wr_frame_i (wr_frame),
    .wr_row_i   (wr_row),
    .wr_data_i  (wr_data),
    .rd_idx_i   (idx_q),
    .rd_mat_o   (front_mat)
  );

  // Sequencing state: phase, current layer and in-phase cycle count.
  always_ff @(posedge clock or posedge reset) begin
    if (reset) begin
      state_q <= ST_IDLE;
      idx_q   <= '0;
      cnt_q   <= '0;
    end else begin
      state_q <= state_d;
      idx_q   <= idx_d;
      cnt_q   <= cnt_d;
    end
  end

  // Next phase/layer; load0 marks every transition that (re)loads layer 0.
  always_comb begin
    state_d = state_q;
    idx_d   = idx_q;
    cnt_d   = cnt_q + CNT_W'(1);
    load0   = 1'b0;
    restart = sync && (state_q != ST_IDLE);
    if (!enable) begin
      state_d = ST_IDLE;
      idx_d   = '0;
      cnt_d   = '0;
    end else if (state_q == ST_IDLE || restart) begin
      state_d = ST_SHOW;
      idx_d   = '0;
      cnt_d   = '0;
      load0   = 1'b1;
    end else if (state_q == ST_SHOW && cnt_q == DWELL_LAST) begin
      cnt_d = '0;
      if (BLANK == 0) begin
        idx_d = next_layer(idx_q, NFRAME);
        load0 = (idx_d == '0);
      end else begin
        state_d = ST_BLANK;
      end
    end else if (state_q == ST_BLANK && cnt_q == BLANK_LAST) begin
      state_d = ST_SHOW;
      cnt_d   = '0;
      idx_d   = next_layer(idx_q, NFRAME);
      load0   = (idx_d == '0);
    end
  end

  // Swap handshake and next values of the registered driver outputs.
  always_comb begin
    do_swap   = pending_q && (state_q == ST_IDLE || load0);
    pending_d = pending_q;
    if (do_swap) pending_d = 1'b0;
    else if (swap_req) pending_d = 1'b1;
    swap_ack_d    = do_swap;
    mat_d         = (state_q == ST_SHOW) ? front_mat : '0;
    frame_idx_d   = idx_q;
    frame_start_d = (state_q == ST_SHOW) && (cnt_q == '0);
  end

  // Output and handshake registers.
  always_ff @(posedge clock or posedge reset) begin
    if (reset) begin
      pending_q     <= 1'b0;
      swap_ack_q    <= 1'b0;
      mat_q         <= '0;
      frame_idx_q   <= '0;
      frame_start_q <= 1'b0;
    end else begin
      pending_q     <= pending_d;
      swap_ack_q    <= swap_ack_d;
      mat_q         <= mat_d;
      frame_idx_q   <= frame_idx_d;
      frame_start_q <= frame_start_d;
    end
  end

  assign wr_ready    = ~pending_q;
  assign swap_ack    = swap_ack_q;
  assign mat         = mat_q;
  assign frame_idx   = frame_idx_q;
  assign frame_start = frame_start_q;

endmodule

// File: tb/tb_frame_sequencer.sv
// Scoreboard bench for frame_sequencer (NFRAME=2, DWELL=4, BLANK=1).
module tb_frame_sequencer;

  localparam int NF = 2;
  localparam int DW = 4;
  localparam int BL = 1;
  localparam int P  = DW + BL;

  logic         clock, reset, enable, sync, wr_en, swap_req;
  logic         wr_ready, swap_ack, frame_start;
  logic [3:0]   wr_frame, wr_row, frame_idx;
  logic [0:15]  wr_data;
  logic [0:255] mat;

  int tests  = 0;
  int failed = 0;

  typedef struct {
    logic [0:255] mat;
    logic [3:0]   idx;
    logic         fs;
    logic         ack;
    logic         rdy;
  } exp_t;

  exp_t exp_q[$];

  // Reference model: the whole volume is one timeline of NF*P clocks.
  logic [0:15] mbank [0:1][0:NF-1][0:15];
  bit          m_on, m_front, m_pend;
  int          m_tau;

  frame_sequencer #(.NFRAME(NF), .DWELL(DW), .BLANK(BL)) dut (
    .clock       (clock),
    .reset       (reset),
    .enable      (enable),
    .sync        (sync),
    .wr_en       (wr_en),
    .wr_ready    (wr_ready),
    .wr_frame    (wr_frame),
    .wr_row      (wr_row),
    .wr_data     (wr_data),
    .swap_req    (swap_req),
    .swap_ack    (swap_ack),
    .mat         (mat),
    .frame_idx   (frame_idx),
    .frame_start (frame_start)
  );

  initial clock = 1'b0;
  always #5 clock = ~clock;

  function automatic logic [0:255] model_frame(input bit b, input bit l);
    logic [0:255] v;
    v = '0;
    for (int r = 0; r < 16; r++) v[r*16 +: 16] = mbank[b][l][4'(r)];
    return v;
  endfunction

  always @(posedge clock or posedge reset) begin
    exp_t e;
    int   ph, layer;
    bit   on_pre, load0, exec;
    if (reset) begin
      m_on = 0; m_tau = 0; m_front = 0; m_pend = 0;
      exp_q.delete();
    end else begin
      ph    = m_tau % P;
      layer = (m_tau / P) % NF;
      if (m_on && ph < DW) begin
        e.mat = model_frame(m_front, 1'(layer));
        e.fs  = (ph == 0);
      end else begin
        e.mat = '0;
        e.fs  = 1'b0;
      end
      e.idx = m_on ? 4'(layer) : 4'd0;
      if (wr_en && !m_pend) mbank[!m_front][1'(wr_frame)][wr_row] = wr_data;
      on_pre = m_on;
      load0  = 0;
      if (!enable) begin
        m_on = 0; m_tau = 0;
      end else if (!m_on || sync) begin
        m_on = 1; m_tau = 0; load0 = 1;
      end else begin
        m_tau++;
        if (m_tau == NF * P) begin m_tau = 0; load0 = 1; end
      end
      exec = m_pend && (!on_pre || load0);
      if (exec) begin
        m_front = !m_front;
        m_pend  = 0;
      end else if (swap_req) begin
        m_pend = 1;
      end
      e.ack = exec;
      e.rdy = !m_pend;
      exp_q.push_back(e);
    end
  end

  // Monitor: one expected entry per clock edge, compared away from the edge.
  always @(negedge clock) begin
    exp_t e;
    if (!reset && exp_q.size() > 0) begin
      e = exp_q.pop_front();
      tests++;
      if (mat !== e.mat || frame_idx !== e.idx || frame_start !== e.fs ||
          swap_ack !== e.ack || wr_ready !== e.rdy) begin
        failed++;
        $display("FAIL outputs t=%0t: mat=%h idx=%0d fs=%b ack=%b rdy=%b | want mat=%h idx=%0d fs=%b ack=%b rdy=%b",
                 $time, mat, frame_idx, frame_start, swap_ack, wr_ready,
                 e.mat, e.idx, e.fs, e.ack, e.rdy);
      end
    end
  end

  task automatic chk(input string name, input logic [255:0] act, input logic [255:0] want);
    tests++;
    if (act !== want) begin
      failed++;
      $display("FAIL %s: got %h want %h", name, act, want);
    end
  endtask

  task automatic idle_in();
    sync = 0; swap_req = 0; wr_en = 0;
  endtask

  task automatic cycles(input int n);
    for (int i = 0; i < n; i++) begin
      @(negedge clock);
      idle_in();
    end
  endtask

  task automatic write_row(input int f, input int r, input logic [15:0] d);
    @(negedge clock);
    idle_in();
    wr_en = 1; wr_frame = 4'(f); wr_row = 4'(r); wr_data = d;
  endtask

  task automatic pulse_swap();
    @(negedge clock);
    idle_in();
    swap_req = 1;
  endtask

  task automatic check_reset_values(input string tag);
    chk({tag, "_mat"}, mat, '0);
    chk({tag, "_idx"}, frame_idx, 0);
    chk({tag, "_fs"}, frame_start, 0);
    chk({tag, "_ack"}, swap_ack, 0);
    chk({tag, "_rdy"}, wr_ready, 1);
  endtask

  initial begin
    bit ok;
    reset = 1; enable = 0; sync = 0; wr_en = 0; swap_req = 0;
    wr_frame = 0; wr_row = 0; wr_data = 0;
    repeat (2) @(negedge clock);
    reset = 0;
    #1 check_reset_values("reset");

    // Fill both banks with random rows, swapping while idle.
    for (int b = 0; b < 2; b++) begin
      for (int f = 0; f < NF; f++)
        for (int r = 0; r < 16; r++) write_row(f, r, 16'($urandom));
      pulse_swap();
      cycles(3);
    end

    // Free run over more than two volumes.
    @(negedge clock); idle_in(); enable = 1;
    cycles(24);

    // Write layer 1 row 3 of the back bank, then swap at the next wrap.
    write_row(1, 3, 16'hA5A5);
    pulse_swap();
    ok = 0;
    for (int i = 0; i < 40 && !ok; i++) begin
      @(negedge clock); idle_in();
      if (swap_ack) ok = 1;
    end
    chk("swap_ack_seen", ok, 1);
    ok = 0;
    for (int i = 0; i < 20 && !ok; i++) begin
      @(negedge clock);
      if (frame_start && frame_idx == 4'd1) ok = 1;
    end
    chk("layer1_start_seen", ok, 1);
    chk("layer1_row3", mat[48 +: 16], 16'hA5A5);
    cycles(4);

    // Swap request mid layer, writes while not ready, duplicate request.
    pulse_swap();
    write_row(0, 5, 16'h1234);
    write_row(1, 7, 16'hBEEF);
    pulse_swap();
    cycles(14);

    // Sync part-way through layer 1 with a swap pending.
    ok = 0;
    for (int i = 0; i < 20 && !ok; i++) begin
      @(negedge clock); idle_in();
      if (frame_start && frame_idx == 4'd1) ok = 1;
    end
    chk("sync_setup", ok, 1);
    pulse_swap();
    @(negedge clock); idle_in(); sync = 1;
    cycles(12);

    // Drop enable mid-show, then re-enable.
    cycles(2);
    @(negedge clock); idle_in(); enable = 0;
    cycles(3);
    @(negedge clock); idle_in(); enable = 1;
    cycles(12);

    // Asynchronous reset inside BLANK with a swap pending.
    ok = 0;
    for (int i = 0; i < 20 && !ok; i++) begin
      @(negedge clock); idle_in();
      if (frame_start) ok = 1;
    end
    chk("blank_setup", ok, 1);
    swap_req = 1;
    @(negedge clock); idle_in();
    repeat (2) @(posedge clock);
    #2 reset = 1;
    #1 check_reset_values("async_reset");
    @(posedge clock);
    @(negedge clock); reset = 0;
    cycles(22);

    // Randomised traffic.
    for (int i = 0; i < 700; i++) begin
      @(negedge clock);
      if ($urandom_range(0, 99) < 2) enable = ~enable;
      sync     = ($urandom_range(0, 99) < 3);
      swap_req = ($urandom_range(0, 99) < 6);
      wr_en    = 1'($urandom_range(0, 1));
      wr_frame = 4'($urandom_range(0, 15));
      wr_row   = 4'($urandom_range(0, 15));
      wr_data  = 16'($urandom);
    end
    idle_in();
    cycles(3);
    chk("queue_drained", exp_q.size() <= 1, 1);
    $display("[TB] %0d tests run, %0d failed", tests, failed);
    $finish;
  end

endmodule
